// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcodes, function codes, FSM states and the instruction
// decode shared by the issue controller.
package alu_issue_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_LT   = 1;
    localparam int FLAG_OVF  = 2;

    // The ALU always sees its operands at these register numbers.
    localparam logic [4:0] ALU_RS_ADDR = 5'b00000;
    localparam logic [4:0] ALU_RT_ADDR = 5'b00001;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    // What an instruction does at write-back.
    typedef enum logic [1:0] {K_NONE, K_RES, K_SLT, K_BR} kind_t;

    typedef struct packed {
        kind_t      kind;
        logic       ovf_chk;
        logic [4:0] dest;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d.kind    = K_NONE;
        d.ovf_chk = 1'b0;
        d.dest    = (instr[31:26] == OP_RTYPE) ? instr[15:11] : instr[20:16];
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR: d.kind = K_RES;
                    FN_ADD, FN_SUB: begin
                        d.kind    = K_RES;
                        d.ovf_chk = 1'b1;
                    end
                    FN_SLT, FN_SLTU: d.kind = K_SLT;
                    default: d.kind = K_NONE;
                endcase
            end
            OP_ADDI: begin
                d.kind    = K_RES;
                d.ovf_chk = 1'b1;
            end
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: d.kind = K_RES;
            OP_SLTI, OP_SLTIU:                  d.kind = K_SLT;
            OP_BEQ, OP_BNE:                     d.kind = K_BR;
            default:                            d.kind = K_NONE;  // lw, sw, others
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_rf.sv
// alu_issue_rf: 32x32 register file, two async read ports, one write port.
// r0 always reads zero and ignores writes.
module alu_issue_rf
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra_addr,
    output logic [31:0] ra_data,
    input  logic [4:0]  rb_addr,
    output logic [31:0] rb_data,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem [32];

    // Write port; whole array clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data = (ra_addr == 5'd0) ? '0 : mem[ra_addr];
    assign rb_data = (rb_addr == 5'd0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: serial issue controller for an external combinational MIPS ALU.
// IDLE -> READ -> EXEC -> WB, one instruction in flight at a time.
// Optional macro ALU_ISSUE_OVF_TRAP_EN: overflow on add/sub/addi suppresses
// write-back and raises a sticky trap cleared by trap_clr.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [31:0] alu_instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        branch_taken,
    output logic        busy
`ifdef ALU_ISSUE_OVF_TRAP_EN
    ,
    output logic        trap,
    input  logic        trap_clr
`endif
);

    state_t      state_q, state_d;
    logic [31:0] instr_q, res_q;
    logic [2:0]  flags_q;
    logic [31:0] rd_a, rd_b;
    logic        ovf_hit, blocked, wr;
    dec_t        dec;

    assign dec     = decode(instr_q);
    assign ovf_hit = dec.ovf_chk && flags_q[FLAG_OVF];

`ifdef ALU_ISSUE_OVF_TRAP_EN
    assign blocked = trap;

    // Sticky trap: set when an overflowing add/sub/addi leaves WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          trap <= 1'b0;
        else if (state_q == S_WB && ovf_hit) trap <= 1'b1;
        else if (trap_clr)                   trap <= 1'b0;
    end
`else
    logic unused_ovf;
    assign blocked    = 1'b0;
    assign unused_ovf = ovf_hit;
`endif

    alu_issue_rf u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (instr_q[25:21]),
        .ra_data (rd_a),
        .rb_addr (instr_q[20:16]),
        .rb_data (rd_b),
        .we      (wb_valid),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = !blocked;
                if (in_valid && !blocked) state_d = S_READ;
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Instruction latch, ALU operand drive, result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= '0;
            alu_instr <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            res_q     <= '0;
            flags_q   <= '0;
        end else begin
            if (in_valid && in_ready) instr_q <= in_instr;
            if (state_q == S_READ) begin
                alu_instr <= {instr_q[31:26], ALU_RS_ADDR, ALU_RT_ADDR, instr_q[15:0]};
                alu_a     <= rd_a;
                alu_b     <= rd_b;
            end
            if (state_q == S_EXEC) begin
                res_q   <= alu_result;
                flags_q <= alu_flags;
            end
        end
    end

    // Write-back report and branch pulse, live only in WB.
    always_comb begin
        wr = (state_q == S_WB) && (dec.kind == K_RES || dec.kind == K_SLT)
             && (dec.dest != 5'd0);
`ifdef ALU_ISSUE_OVF_TRAP_EN
        wr = wr && !ovf_hit;
`endif
        wb_valid     = wr;
        wb_addr      = wr ? dec.dest : 5'd0;
        wb_data      = !wr ? 32'd0 :
                       (dec.kind == K_SLT) ? {31'd0, flags_q[FLAG_LT]} : res_q;
        branch_taken = (state_q == S_WB) && (dec.kind == K_BR) && flags_q[FLAG_ZERO];
    end

endmodule
